// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one registered adder between NUM_REQ requesters.
// One operation is in flight at a time. A watchdog completes an unanswered operation with rsp_err set.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_data0,
  input  logic [NUM_REQ*32-1:0]   req_data1,
  output logic                    add_dv,
  output logic [31:0]             add_data0,
  output logic [31:0]             add_data1,
  input  logic [31:0]             add_data_out,
  input  logic                    add_dv_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic [7:0]       cnt_reg;
  logic [7:0]       cnt_next;
  logic [SEL_W-1:0] grant_sel;
  logic             grant_any;
  logic [31:0]      op0 [NUM_REQ];
  logic [31:0]      op1 [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op0[gi]       = req_data0[32*gi +: 32];
      assign op1[gi]       = req_data1[32*gi +: 32];
      assign req_ready[gi] = reset && (state_reg == IDLE) && grant_any &&
                             (grant_sel == SEL_W'(gi));
    end
  endgenerate

  // Scan from the farthest candidate down to ptr+1 so the nearest valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_sel = '0;
    grant_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx[SEL_W-1:0]]) begin
        grant_sel = idx[SEL_W-1:0];
        grant_any = 1'b1;
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign cnt_next = cnt_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= SEL_W'(NUM_REQ - 1);
      cnt_reg   <= '0;
      add_dv    <= 1'b0;
      add_data0 <= '0;
      add_data1 <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            add_data0 <= op0[grant_sel];
            add_data1 <= op1[grant_sel];
            rsp_id    <= ID_W'(grant_sel);
            ptr_reg   <= grant_sel;
            add_dv    <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          add_dv    <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // An answer on the timeout edge takes priority over the error.
          if (add_dv_out) begin
            rsp_data  <= add_data_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else if (cnt_next == 8'(TIMEOUT)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a registered adder model and a response scoreboard.
// Table-driven grant vectors, plus hand-written multi-cycle corner cases.
module tb_adder_arbiter;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_data0 = '0;
  logic [127:0] req_data1 = '0;
  logic         add_dv;
  logic [31:0]  add_data0;
  logic [31:0]  add_data1;
  logic [31:0]  add_data_out = '0;
  logic         add_dv_out = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_err;
  logic         busy;

  logic adder_en = 1'b1;
  logic force_dv_out = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  valid;
    int          grant;
    logic [31:0] sum;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[9];

  always #5 clk = ~clk;

  adder_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .add_dv(add_dv), .add_data0(add_data0), .add_data1(add_data1),
    .add_data_out(add_data_out), .add_dv_out(add_dv_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  // Adder model: one-cycle registered latency, can be silenced or forced.
  always @(posedge clk) begin
    add_dv_out   <= (add_dv & adder_en) | force_dv_out;
    add_data_out <= add_data0 + add_data1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every completed response must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", {30'd0, rsp_id}, {30'd0, mon_e.id});
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
        $display("rsp id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err);
      end
    end
  end

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
    req_data0[32*r +: 32] = a;
    req_data1[32*r +: 32] = b;
  endtask

  // Waits (bounded) for a grant, checks it and records the expected response.
  task automatic wait_ready(input int exp_grant, input logic [31:0] exp_sum, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == 4'd0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_grant", {28'd0, req_ready}, 32'd1 << exp_grant);
    exp_q.push_back('{id: 2'(exp_grant), data: exp_sum, err: exp_err});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b1111, 0, 32'd0};
    vecs[1] = '{4'b1111, 1, 32'd101};
    vecs[2] = '{4'b1111, 2, 32'd202};
    vecs[3] = '{4'b1111, 3, 32'd303};
    vecs[4] = '{4'b1111, 0, 32'd0};
    vecs[5] = '{4'b0100, 2, 32'd202};
    vecs[6] = '{4'b0100, 2, 32'd202};
    vecs[7] = '{4'b1010, 3, 32'd303};
    vecs[8] = '{4'b1010, 1, 32'd101};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_add_dv", {31'd0, add_dv}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single op with cycle-exact timing
    set_ops(0, 32'd5, 32'd7);
    req_valid = 4'b0001;
    wait_ready(0, 32'd12, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("single_add_dv_t1", {31'd0, add_dv}, 32'd1);
    check("single_add_data0", add_data0, 32'd5);
    check("single_add_data1", add_data1, 32'd7);
    @(negedge clk);
    check("single_add_dv_t2", {31'd0, add_dv}, 32'd0);
    check("single_rsp_valid_t2", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("single_rsp_valid_t3", {31'd0, rsp_valid}, 32'd1);
    check("single_rsp_data_t3", rsp_data, 32'd12);
    wait_drain();

    // Round robin and sparse requests from a fresh pointer
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 32'(i), 32'(100 * i));
    for (int v = 0; v < 9; v++) begin
      req_valid = vecs[v].valid;
      wait_ready(vecs[v].grant, vecs[v].sum, 1'b0);
      @(posedge clk);
      #1;
    end
    req_valid = 4'b0000;
    wait_drain();

    // Backpressure with 32-bit wraparound
    set_ops(0, 32'hFFFF_FFFF, 32'd2);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_ready(0, 32'd1, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", rsp_data, 32'd1);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_req_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_done_busy", {31'd0, busy}, 32'd0);
    wait_drain();

    // Watchdog timeout
    adder_en = 1'b0;
    set_ops(1, 32'd3, 32'd4);
    req_valid = 4'b0010;
    wait_ready(1, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) check("to_rsp_valid_early", {31'd0, rsp_valid}, 32'd0);
      if (k == 17) begin
        check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
      end
    end
    wait_drain();
    adder_en = 1'b1;

    // Normal op after a timeout
    set_ops(2, 32'd10, 32'd20);
    req_valid = 4'b0100;
    wait_ready(2, 32'd30, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    wait_drain();

    // Answer arriving on the timeout edge wins
    adder_en = 1'b0;
    set_ops(3, 32'd100, 32'd23);
    req_valid = 4'b1000;
    wait_ready(3, 32'd123, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 15) force_dv_out = 1'b1;
      if (k == 16) force_dv_out = 1'b0;
      if (k == 17) check("edge_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    wait_drain();

    // Reset in the middle of an operation
    set_ops(1, 32'd9, 32'd9);
    req_valid = 4'b0010;
    wait_ready(1, 32'd18, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 4'b1111;
    exp_q.delete();
    @(negedge clk);
    check("mid_req_ready_in_reset", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_add_dv", {31'd0, add_dv}, 32'd0);
    check("mid_add_data0", add_data0, 32'd0);
    check("mid_add_data1", add_data1, 32'd0);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rsp_id", {30'd0, rsp_id}, 32'd0);
    check("mid_rsp_data", rsp_data, 32'd0);
    check("mid_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_req_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 4'b0000;
    force_dv_out = 1'b1;
    adder_en = 1'b1;
    @(posedge clk);
    #1;
    force_dv_out = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stale_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("stale_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    set_ops(0, 32'd1, 32'd2);
    req_valid = 4'b1111;
    wait_ready(0, 32'd3, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one external `adder` instance (1-cycle registered latency, pulse `dv` in, pulse `dv_out` back) between NUM_REQ requesters.
- Round-robin arbitration with one operation in flight at a time.
- Per-requester valid/ready operand ports; a single tagged response port with valid/ready handshake.
- Watchdog: if the adder never answers, the operation completes with an error flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of the requester tag (≥ clog2(NUM_REQ)).
- TIMEOUT, 15, WAIT-state cycles without `add_dv_out` before error completion (1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending per requester.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_data0  in  NUM_REQ*32  operand A; requester i in bits [32i+31:32i].
- req_data1  in  NUM_REQ*32  operand B, same packing.
- add_dv  out  1  to adder `dv`.
- add_data0  out  32  to adder `data0_in`.
- add_data1  out  32  to adder `data1_in`.
- add_data_out  in  32  from adder `data_out`.
- add_dv_out  in  1  from adder `dv_out`.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  ID_W  index of the requester that issued the op.
- rsp_data  out  32  sum, modulo 2^32.
- rsp_err  out  1  1 = watchdog timeout, rsp_data = 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset = 0 at a clock edge):
  - State = IDLE, round-robin pointer = NUM_REQ-1.
  - Watchdog counter = 0.
  - add_dv, add_data0, add_data1, rsp_valid, rsp_id, rsp_data, rsp_err, busy = 0.
  - req_ready = 0 during reset.
- Reset mid-operation aborts the operation silently. No response is issued, and a late `add_dv_out` is ignored because the state is IDLE. The requester must resubmit.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching ptr+1, ptr+2, … modulo NUM_REQ.
  - req_ready[g] = 1 combinationally, all other bits 0; req_ready = 0 if no req_valid.
  - On the handshake edge: latch operands into add_data0/1, store g as tag, ptr <= g, go to ISSUE.
- ISSUE (exactly 1 cycle): add_dv = 1; go to WAIT and clear the watchdog counter.
- WAIT:
  - add_dv = 0; add_data0/1 held.
  - If add_dv_out = 1: rsp_data <= add_data_out, rsp_err <= 0, go to RESP.
  - Else increment the counter. When it reaches TIMEOUT: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - A `dv_out` that arrives on the same edge as the timeout wins: no error.
- RESP:
  - rsp_valid = 1; rsp_id/rsp_data/rsp_err stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
- No requests are accepted outside IDLE, so req_ready = 0 when busy = 1.
- add_dv_out outside WAIT is ignored.
- Timing with a compliant adder and rsp_ready tied to 1:
  - Accept at cycle T; add_dv high in T+1; add_dv_out seen in T+2.
  - rsp_valid high in T+3; next accept possible in T+4.
  - Throughput is one operation per 4 cycles.
- Overflow: the carry out of bit 31 is discarded (e.g. FFFFFFFF + 2 = 00000001). No overflow flag.
- Requester persistence: a requester that drops req_valid before acceptance is simply not granted. Operands are sampled only on the handshake edge.

Test Plan:
- Single op: req0 = (5, 7), rsp_ready = 1.
  - req_ready[0] pulses at T, add_dv at T+1.
  - At T+3: rsp_valid = 1, rsp_id = 0, rsp_data = 12, rsp_err = 0.
- Round robin: all 4 req_valid held high after reset, operands (i, 100·i).
  - Grant order 0,1,2,3,0.
  - rsp_data values 0, 101, 202, 303, 0.
  - Each rsp_id matches its grant.
- Backpressure: rsp_ready = 0 for 10 cycles after rsp_valid on (0xFFFFFFFF, 2).
  - rsp_data = 1 held stable, busy = 1, req_ready = 0 throughout.
  - Completes one cycle after rsp_ready rises.
- Timeout: adder model never returns dv_out, TIMEOUT = 15.
  - rsp_valid rises 15 cycles after entering WAIT, with rsp_err = 1, rsp_data = 0.
  - A subsequent normal op returns rsp_err = 0.
- Reset mid-op: assert reset (low) during WAIT.
  - All outputs are 0 on the next cycle.
  - A stale add_dv_out is ignored: no rsp_valid.
  - After release, requester 0 is granted first.
- Sparse requests: only req2 is valid while ptr = 2.
  - req2 is granted again (the search wraps).
  - rsp_id = 2.
